mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline, between the EX/MEM and MEM/WB pipeline registers. Issues loads and stores to the data memory over a valid/ready request channel and a response-valid return channel, with one transaction outstanding at a time. Aligns and sign- or zero-extends load data and generates byte strobes for stores. Registers the MEM/WB bundle consumed by the writeback stage, and stalls upstream while a memory access is in flight.

---
 rtl/mem_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues one load/store at a time on the
// data-memory channel, formats load data, and registers the MEM/WB bundle.
module mem_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        EX_MEM_valid,
  input  logic [31:0] EX_MEM_pc,
  input  logic [31:0] EX_MEM_inst,
  input  logic [31:0] EX_MEM_alu,
  input  logic [31:0] EX_MEM_rs2,
  input  logic [4:0]  EX_MEM_rd,
  output logic        MEM_STALL,
  output logic        DMEM_req,
  output logic        DMEM_we,
  output logic [31:0] DMEM_addr,
  output logic [31:0] DMEM_wdata,
  output logic [3:0]  DMEM_wstrb,
  input  logic        DMEM_ready,
  input  logic        DMEM_rvalid,
  input  logic [31:0] DMEM_rdata,
  output logic        MEM_WB_valid,
  output logic [31:0] MEM_WB_pc,
  output logic [31:0] MEM_WB_inst,
  output logic [31:0] MEM_WB_alu,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_data,
  output logic        MEM_WB_fault,
  output logic [1:0]  DBG_state
);

  // Channel handshake: a request is accepted at a rising edge where DMEM_req and
  // DMEM_ready are both high; DMEM_rvalid is honoured only in WAIT, one cycle or
  // more after the accepting edge. EX/MEM is held stable while MEM_STALL is high.

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_fault_q, wb_fault_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load, is_store, mem_op;
  logic        bad_f3, misalign, fault, go;
  logic        req_raw, capture;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  assign opcode = EX_MEM_inst[6:0];
  assign funct3 = EX_MEM_inst[14:12];
  assign off    = EX_MEM_alu[1:0];

  assign is_load  = EX_MEM_valid && (opcode == OP_LOAD);
  assign is_store = EX_MEM_valid && (opcode == OP_STORE);
  assign mem_op   = is_load || is_store;

  assign bad_f3   = is_load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                            : (funct3 > 3'b010);
  assign misalign = ((funct3[1:0] == 2'b01) && off[0]) ||
                    ((funct3[1:0] == 2'b10) && (off != 2'b00));
  assign fault    = mem_op && (bad_f3 || misalign);
  assign go       = mem_op && !fault;

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = EX_MEM_rs2;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << off;
          st_wdata = {4{EX_MEM_rs2[7:0]}};
        end
        2'b01: begin
          st_wstrb = 4'b0011 << off;
          st_wdata = {2{EX_MEM_rs2[15:0]}};
        end
        default: st_wstrb = 4'b1111;
      endcase
    end
  end

  assign ld_byte = DMEM_rdata[8*off +: 8];
  assign ld_half = DMEM_rdata[16*off[1] +: 16];

  always_comb begin
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = DMEM_rdata;
    endcase
  end

  // capture = MEM/WB takes a new bundle (or a bubble) this edge; otherwise we stall.
  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          req_raw = 1'b1;
          if (DMEM_ready) begin
            if (is_store) capture = 1'b1;
            else          state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end else begin
          capture = 1'b1;
        end
      end
      REQ: begin
        req_raw = 1'b1;
        if (DMEM_ready) begin
          if (is_store) begin
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (DMEM_rvalid) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_pc_d    = 32'h0;
    wb_inst_d  = NOP_INST;
    wb_alu_d   = 32'h0;
    wb_rd_d    = 5'd0;
    wb_data_d  = 32'h0;
    wb_fault_d = 1'b0;
    if (capture && EX_MEM_valid) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = EX_MEM_pc;
      wb_inst_d  = EX_MEM_inst;
      wb_alu_d   = EX_MEM_alu;
      if (fault) begin
        wb_fault_d = 1'b1;
      end else begin
        wb_rd_d   = EX_MEM_rd;
        wb_data_d = is_load ? ld_data : EX_MEM_alu;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= 32'h0;
      wb_inst_q  <= NOP_INST;
      wb_alu_q   <= 32'h0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_inst_q  <= wb_inst_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  // Request and stall are gated by reset so both read low while RES is held.
  assign DMEM_req   = RES && req_raw;
  assign MEM_STALL  = RES && !capture;
  assign DMEM_we    = is_store;
  assign DMEM_addr  = {EX_MEM_alu[31:2], 2'b00};
  assign DMEM_wdata = st_wdata;
  assign DMEM_wstrb = st_wstrb;

  assign MEM_WB_valid = wb_valid_q;
  assign MEM_WB_pc    = wb_pc_q;
  assign MEM_WB_inst  = wb_inst_q;
  assign MEM_WB_alu   = wb_alu_q;
  assign MEM_WB_rd    = wb_rd_q;
  assign MEM_WB_data  = wb_data_q;
  assign MEM_WB_fault = wb_fault_q;
  assign DBG_state    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions against a behavioural model of the RV32I load/store rules.
module tb_mem_stage;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd2;

  logic        CLK, RES;
  logic        EX_MEM_valid;
  logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2;
  logic [4:0]  EX_MEM_rd;
  logic        MEM_STALL, DMEM_req, DMEM_we;
  logic [31:0] DMEM_addr, DMEM_wdata;
  logic [3:0]  DMEM_wstrb;
  logic        DMEM_ready, DMEM_rvalid;
  logic [31:0] DMEM_rdata;
  logic        MEM_WB_valid, MEM_WB_fault;
  logic [31:0] MEM_WB_pc, MEM_WB_inst, MEM_WB_alu, MEM_WB_data;
  logic [4:0]  MEM_WB_rd;
  logic [1:0]  DBG_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  mem_stage #(.NOP_INST(NOP)) dut (
    .CLK(CLK), .RES(RES),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_pc(EX_MEM_pc), .EX_MEM_inst(EX_MEM_inst),
    .EX_MEM_alu(EX_MEM_alu), .EX_MEM_rs2(EX_MEM_rs2), .EX_MEM_rd(EX_MEM_rd),
    .MEM_STALL(MEM_STALL), .DMEM_req(DMEM_req), .DMEM_we(DMEM_we),
    .DMEM_addr(DMEM_addr), .DMEM_wdata(DMEM_wdata), .DMEM_wstrb(DMEM_wstrb),
    .DMEM_ready(DMEM_ready), .DMEM_rvalid(DMEM_rvalid), .DMEM_rdata(DMEM_rdata),
    .MEM_WB_valid(MEM_WB_valid), .MEM_WB_pc(MEM_WB_pc), .MEM_WB_inst(MEM_WB_inst),
    .MEM_WB_alu(MEM_WB_alu), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data),
    .MEM_WB_fault(MEM_WB_fault), .DBG_state(DBG_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd);
    return {12'h0A5, 5'd2, f3, rd, op};
  endfunction

  function automatic void model(input logic valid, input logic [31:0] inst, alu, rs2, rdata,
                                output logic is_ld, is_st, flt, output logic [3:0] strb,
                                output logic [31:0] wd, data);
    int size, off;
    logic legal;
    logic [31:0] v, mask;
    is_ld = valid && (inst[6:0] == 7'h03);
    is_st = valid && (inst[6:0] == 7'h23);
    size  = 1 << inst[13:12];
    off   = int'(alu[1:0]);
    legal = is_ld ? (inst[14:12] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (inst[14:12] <= 3'd2);
    flt   = (is_ld || is_st) && !(legal && ((alu % size) == 0));
    strb  = 4'b0000;
    wd    = rs2;
    if (is_st) begin
      strb = 4'(((1 << size) - 1) << off);
      if (size == 1)      wd = {24'h0, rs2[7:0]} * 32'h01010101;
      else if (size == 2) wd = {16'h0, rs2[15:0]} * 32'h00010001;
    end
    mask = (size >= 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (rdata >> (8 * off)) & mask;
    if (!inst[14] && size < 4 && v[8*size-1]) v = v | ~mask;
    if (!valid || flt) data = 32'h0;
    else if (is_ld)    data = v;
    else               data = alu;
  endfunction

  // ---------------- driver: one EX/MEM instruction, acting as memory too ----------------
  task automatic do_txn(input string name, input logic v, input logic [31:0] inst, alu, rs2,
                        rdata, input logic [4:0] rd, input int rdly, vdly);
    logic is_ld, is_st, flt, acc, done, req_now, stall_now, exp_req;
    logic [3:0]  strb;
    logic [31:0] wd, data, pc, exp_data;
    int exp_stall, stalls, cyc, wcnt;
    model(v, inst, alu, rs2, rdata, is_ld, is_st, flt, strb, wd, data);
    exp_q.push_back(data);
    exp_stall = (flt || !(is_ld || is_st)) ? 0 : (is_st ? rdly : rdly + 1 + vdly);
    pc = $urandom & 32'hFFFFFFFC;
    EX_MEM_valid = v; EX_MEM_pc = pc; EX_MEM_inst = inst;
    EX_MEM_alu = alu; EX_MEM_rs2 = rs2; EX_MEM_rd = rd;
    cyc = 0; wcnt = 0; acc = 1'b0; stalls = 0; done = 1'b0;
    while (!done) begin
      DMEM_ready  = !acc && (cyc >= rdly);
      DMEM_rvalid = acc ? (wcnt >= vdly) : (!DMEM_ready && ($urandom_range(0, 1) == 1));
      DMEM_rdata  = (acc && wcnt >= vdly) ? rdata : $urandom;
      @(negedge CLK);
      req_now   = DMEM_req;
      stall_now = MEM_STALL;
      exp_req   = (is_ld || is_st) && !flt && !acc;
      n_checks++;
      if (req_now !== exp_req) begin
        n_fail++;
        $display("FAIL %s dmem_req cyc %0d: got %b want %b", name, cyc, req_now, exp_req);
      end
      if (exp_req) begin
        n_checks++;
        if ({DMEM_we, DMEM_addr, DMEM_wstrb} !== {is_st, alu & 32'hFFFFFFFC, strb}) begin
          n_fail++;
          $display("FAIL %s dmem_cmd: got we=%b addr=%h strb=%b want we=%b addr=%h strb=%b",
                   name, DMEM_we, DMEM_addr, DMEM_wstrb, is_st, alu & 32'hFFFFFFFC, strb);
        end
        if (is_st) begin
          n_checks++;
          if (DMEM_wdata !== wd) begin
            n_fail++;
            $display("FAIL %s dmem_wdata: got %h want %h", name, DMEM_wdata, wd);
          end
        end
      end
      @(posedge CLK); #1;
      if (stall_now) begin
        stalls++;
        n_checks++;
        if ({MEM_WB_valid, MEM_WB_fault, MEM_WB_rd, MEM_WB_pc, MEM_WB_inst, MEM_WB_alu,
             MEM_WB_data} !== {1'b0, 1'b0, 5'd0, 32'h0, NOP, 32'h0, 32'h0}) begin
          n_fail++;
          $display("FAIL %s stall_bubble: got valid=%b inst=%h data=%h want valid=0 inst=%h data=0",
                   name, MEM_WB_valid, MEM_WB_inst, MEM_WB_data, NOP);
        end
      end else begin
        done = 1'b1;
      end
      if (acc) wcnt++;
      if (req_now && DMEM_ready) acc = 1'b1;
      cyc++;
      if (!done && cyc > 64) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: got stall after %0d cycles want completion", name, cyc);
        done = 1'b1;
      end
    end
    DMEM_ready = 1'b0; DMEM_rvalid = 1'b0;
    n_checks++;
    if (stalls != exp_stall) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
    end
    exp_data = exp_q.pop_front();
    n_checks++;
    if (MEM_WB_data !== exp_data) begin
      n_fail++;
      $display("FAIL %s wb_data: got %h want %h", name, MEM_WB_data, exp_data);
    end
    n_checks++;
    if ({MEM_WB_valid, MEM_WB_fault, MEM_WB_rd, MEM_WB_pc, MEM_WB_inst, MEM_WB_alu} !==
        {v, flt, (v && !flt) ? rd : 5'd0, v ? pc : 32'h0, v ? inst : NOP, v ? alu : 32'h0}) begin
      n_fail++;
      $display("FAIL %s wb_fields: got v=%b f=%b rd=%0d pc=%h inst=%h alu=%h want v=%b f=%b",
               name, MEM_WB_valid, MEM_WB_fault, MEM_WB_rd, MEM_WB_pc, MEM_WB_inst,
               MEM_WB_alu, v, flt);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RES = 1'b1;
    EX_MEM_valid = 1'b1; EX_MEM_pc = 32'h0; EX_MEM_inst = mk_inst(7'h03, 3'b010, 5'd4);
    EX_MEM_alu = 32'h40; EX_MEM_rs2 = 32'h0; EX_MEM_rd = 5'd4;
    DMEM_ready = 1'b0; DMEM_rvalid = 1'b0; DMEM_rdata = 32'h0;
    #1 RES = 1'b0;
    #2;
    n_checks++;
    if ({MEM_WB_valid, MEM_WB_fault, MEM_WB_rd, MEM_WB_pc, MEM_WB_inst, MEM_WB_alu, MEM_WB_data,
         DMEM_req, MEM_STALL, DBG_state} !==
        {1'b0, 1'b0, 5'd0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, S_IDLE}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b inst=%h req=%b stall=%b st=%0d want v=0 inst=%h req=0 stall=0 st=0",
               MEM_WB_valid, MEM_WB_inst, DMEM_req, MEM_STALL, DBG_state, NOP);
    end
    EX_MEM_valid = 1'b0;
    @(posedge CLK); #1;
    RES = 1'b1;
  endtask

  task automatic test_alu();
    do_txn("addi", 1'b1, 32'h00500093, 32'd5, 32'h0, 32'h0, 5'd1, 0, 0);
    n_checks++;
    if ({MEM_WB_valid, MEM_WB_data, MEM_WB_rd} !== {1'b1, 32'd5, 5'd1}) begin
      n_fail++;
      $display("FAIL addi_result: got v=%b data=%h rd=%0d want v=1 data=5 rd=1",
               MEM_WB_valid, MEM_WB_data, MEM_WB_rd);
    end
  endtask

  task automatic test_store_sb();
    EX_MEM_valid = 1'b1; EX_MEM_pc = 32'h1000; EX_MEM_inst = mk_inst(7'h23, 3'b000, 5'd0);
    EX_MEM_alu = 32'h103; EX_MEM_rs2 = 32'hAABBCCDD; EX_MEM_rd = 5'd0;
    DMEM_ready = 1'b1; DMEM_rvalid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({DMEM_req, DMEM_we, DMEM_addr, DMEM_wstrb, DMEM_wdata, MEM_STALL} !==
        {1'b1, 1'b1, 32'h100, 4'b1000, 32'hDDDDDDDD, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_request: got req=%b we=%b addr=%h strb=%b wdata=%h stall=%b want 1 1 00000100 1000 dddddddd 0",
               DMEM_req, DMEM_we, DMEM_addr, DMEM_wstrb, DMEM_wdata, MEM_STALL);
    end
    @(posedge CLK); #1;
    DMEM_ready = 1'b0;
    n_checks++;
    if ({MEM_WB_valid, MEM_WB_fault, MEM_WB_data} !== {1'b1, 1'b0, 32'h103}) begin
      n_fail++;
      $display("FAIL sb_capture: got v=%b f=%b data=%h want v=1 f=0 data=00000103",
               MEM_WB_valid, MEM_WB_fault, MEM_WB_data);
    end
  endtask

  task automatic test_load_lh();
    do_txn("lh_wait", 1'b1, mk_inst(7'h03, 3'b001, 5'd7), 32'h202, 32'h0, 32'h80011234,
           5'd7, 2, 2);
    n_checks++;
    if (MEM_WB_data !== 32'hFFFF8001) begin
      n_fail++;
      $display("FAIL lh_value: got %h want ffff8001", MEM_WB_data);
    end
  endtask

  task automatic test_fault();
    do_txn("lw_misaligned", 1'b1, mk_inst(7'h03, 3'b010, 5'd9), 32'h201, 32'h0, 32'h0,
           5'd9, 0, 0);
    do_txn("sh_misaligned", 1'b1, mk_inst(7'h23, 3'b001, 5'd0), 32'h301, 32'h1234, 32'h0,
           5'd0, 0, 0);
    do_txn("load_f3_110", 1'b1, mk_inst(7'h03, 3'b110, 5'd3), 32'h300, 32'h0, 32'h0,
           5'd3, 0, 0);
    do_txn("store_f3_011", 1'b1, mk_inst(7'h23, 3'b011, 5'd0), 32'h308, 32'h5, 32'h0,
           5'd0, 0, 0);
    do_txn("bubble", 1'b0, mk_inst(7'h03, 3'b010, 5'd6), 32'h400, 32'h0, 32'h0, 5'd6, 0, 0);
  endtask

  task automatic test_reset_mid();
    EX_MEM_valid = 1'b1; EX_MEM_pc = 32'h2000; EX_MEM_inst = mk_inst(7'h03, 3'b010, 5'd5);
    EX_MEM_alu = 32'h200; EX_MEM_rs2 = 32'h0; EX_MEM_rd = 5'd5;
    DMEM_ready = 1'b1; DMEM_rvalid = 1'b0;
    @(posedge CLK); #1;
    DMEM_ready = 1'b0;
    n_checks++;
    if (DBG_state !== S_WAIT) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got state %0d want %0d", DBG_state, S_WAIT);
    end
    RES = 1'b0;
    #2;
    n_checks++;
    if ({MEM_WB_valid, MEM_WB_inst, MEM_WB_data, DMEM_req, MEM_STALL, DBG_state} !==
        {1'b0, NOP, 32'h0, 1'b0, 1'b0, S_IDLE}) begin
      n_fail++;
      $display("FAIL mid_reset_state: got v=%b inst=%h req=%b stall=%b st=%0d want 0 %h 0 0 0",
               MEM_WB_valid, MEM_WB_inst, DMEM_req, MEM_STALL, DBG_state, NOP);
    end
    EX_MEM_valid = 1'b0;
    @(negedge CLK);
    RES = 1'b1;
    DMEM_rvalid = 1'b1; DMEM_rdata = 32'hDEADBEEF;
    @(posedge CLK); #1;
    DMEM_rvalid = 1'b0;
    n_checks++;
    if ({MEM_WB_valid, MEM_WB_data, DBG_state} !== {1'b0, 32'h0, S_IDLE}) begin
      n_fail++;
      $display("FAIL stray_rvalid: got v=%b data=%h st=%0d want v=0 data=0 st=0",
               MEM_WB_valid, MEM_WB_data, DBG_state);
    end
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_lbu", 1'b1, mk_inst(7'h03, 3'b100, 5'd8), 32'h500, 32'h0, 32'h000000F0,
           5'd8, 0, 0);
    do_txn("b2b_addi", 1'b1, 32'h00500093, 32'h1234, 32'h0, 32'h0, 5'd1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        do_txn("b2b_sw", 1'b1, mk_inst(7'h23, 3'b010, 5'd0), $urandom & 32'hFFFFFFFC,
               $urandom, 32'h0, 5'd0, 0, 0);
      else
        do_txn("b2b_alu", 1'b1, mk_inst(7'h33, 3'b000, 5'(i)), $urandom, 32'h0, 32'h0,
               5'(i), 0, 0);
    end
  endtask

  task automatic test_random();
    int k;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] alu;
    logic [4:0] rd;
    logic v;
    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 9);
      rd = 5'($urandom_range(1, 31));
      v  = (k != 9);
      f3 = 3'($urandom_range(0, 7));
      if (k < 2)      op = 7'h13;
      else if (k < 6) op = 7'h03;
      else if (k < 9) op = 7'h23;
      else            op = 7'h03;
      if (k >= 2 && k < 5) f3 = (f3 < 3'd5) ? f3 : 3'd4;
      if (k >= 6 && k < 8) f3 = 3'(f3 % 3);
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      do_txn("random", v, mk_inst(op, f3, rd), alu, $urandom, $urandom, rd,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_store_sb();
    test_load_lh();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
